// File: rtl/router_pkg.sv
// Shared header-field definitions, FSM state encoding and parity helper
// for the router source arbiter.
package router_pkg;

    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;
    localparam int HDR_ADDR_W  = 2;
    localparam logic [HDR_ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        PAD,
        PARITY,
        GAP
    } state_e;

    function automatic logic [7:0] parity_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

    function automatic logic hdr_legal(input logic [7:0] hdr);
        return (hdr_len(hdr) != 6'd0) && (hdr[HDR_ADDR_W-1:0] != ADDR_ILLEGAL);
    endfunction

endpackage

// File: rtl/router_rr_arb.sv
// Combinational round-robin picker: the first requester strictly after
// the pointer wins, searching upward with wrap.
module router_rr_arb #(
    parameter int NUM_SRC = 3,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any_req
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        any_req    = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand     = (int'(ptr) + k) % NUM_SRC;
            cand_idx = IDX_W'(cand);
            if (!any_req && req[cand_idx]) begin
                any_req              = 1'b1;
                win_idx              = cand_idx;
                win_onehot           = '0;
                win_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_src_arb.sv
// Shares the router input port between NUM_SRC packet sources: round-robin
// grant per packet, parity generation, underrun padding and inter-packet gap.
module router_src_arb
    import router_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [NUM_SRC-1:0]   src_abort,
    input  logic                 busy,
    input  logic                 err,
    output logic [7:0]           data_in,
    output logic                 pkt_valid,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 hdr_err,
    output logic                 pkt_done,
    output logic                 pkt_err,
    output state_e               dbg_state
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int GAP_W = 3;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_SRC - 1);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         out_byte_q, out_byte_d;
    logic               out_full_q, out_full_d;
    logic               pkt_valid_q, pkt_valid_d;
    logic [5:0]         remaining_q, remaining_d;
    logic [7:0]         parity_q, parity_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               err_seen_q, err_seen_d;
    logic               hdr_err_q, hdr_err_d;
    logic               pkt_done_q, pkt_done_d;
    logic               pkt_err_q, pkt_err_d;
    logic [NUM_SRC-1:0] src_abort_q, src_abort_d;

    logic [NUM_SRC-1:0] arb_onehot;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [7:0]         cur_byte;
    logic               cur_valid;
    logic               consume, can_load, take_state, take;

    router_rr_arb #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_rr_arb (
        .req        (src_valid),
        .ptr        (rr_ptr_q),
        .win_onehot (arb_onehot),
        .win_idx    (arb_idx),
        .any_req    (arb_any)
    );

    // The rr pointer always holds the current owner's index while granted.
    always_comb begin
        cur_byte  = 8'h00;
        cur_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rr_ptr_q == IDX_W'(i)) begin
                cur_byte  = src_data[8*i +: 8];
                cur_valid = src_valid[i];
            end
        end
    end

    // Handshakes: a source byte moves at an edge where src_valid & src_ready;
    // a router byte moves at an edge where out_full & !busy. The output
    // register refills on the same edge it empties, so streams have no bubble.
    assign consume    = out_full_q && !busy;
    assign can_load   = !out_full_q || !busy;
    assign take_state = (state_q == HDR) || ((state_q == PAYLOAD) && (remaining_q != 6'd0));
    assign src_ready  = (take_state && can_load) ? grant_q : '0;
    assign take       = |(src_ready & src_valid);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_byte_d  = out_byte_q;
        out_full_d  = out_full_q;
        pkt_valid_d = pkt_valid_q;
        remaining_d = remaining_q;
        parity_d    = parity_q;
        gap_cnt_d   = gap_cnt_q;
        err_seen_d  = err_seen_q;
        hdr_err_d   = 1'b0;
        pkt_done_d  = 1'b0;
        pkt_err_d   = 1'b0;
        src_abort_d = '0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d  = arb_onehot;
                    rr_ptr_d = arb_idx;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (take) begin
                    if (hdr_legal(cur_byte)) begin
                        out_byte_d  = cur_byte;
                        out_full_d  = 1'b1;
                        pkt_valid_d = 1'b1;
                        remaining_d = hdr_len(cur_byte);
                        parity_d    = cur_byte;
                        state_d     = PAYLOAD;
                    end else begin
                        hdr_err_d = 1'b1;
                        grant_d   = '0;
                        state_d   = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (remaining_q != 6'd0) begin
                    if (take) begin
                        out_byte_d  = cur_byte;
                        out_full_d  = 1'b1;
                        pkt_valid_d = 1'b1;
                        parity_d    = parity_next(parity_q, cur_byte);
                        remaining_d = remaining_q - 6'd1;
                    end else if (consume) begin
                        // Underrun: the first pad byte replaces the missing one.
                        src_abort_d = grant_q;
                        out_byte_d  = 8'h00;
                        pkt_valid_d = 1'b1;
                        remaining_d = remaining_q - 6'd1;
                        state_d     = PAD;
                    end
                end else if (consume) begin
                    out_byte_d  = parity_q;
                    pkt_valid_d = 1'b0;
                    state_d     = PARITY;
                end
            end
            PAD: begin
                if (consume) begin
                    if (remaining_q != 6'd0) begin
                        out_byte_d  = 8'h00;
                        pkt_valid_d = 1'b1;
                        remaining_d = remaining_q - 6'd1;
                    end else begin
                        out_byte_d  = parity_q;
                        pkt_valid_d = 1'b0;
                        state_d     = PARITY;
                    end
                end
            end
            PARITY: begin
                if (consume) begin
                    out_byte_d  = 8'h00;
                    out_full_d  = 1'b0;
                    pkt_valid_d = 1'b0;
                    gap_cnt_d   = '0;
                    err_seen_d  = 1'b0;
                    state_d     = GAP;
                end
            end
            GAP: begin
                err_seen_d = err_seen_q | err;
                if (!busy) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        pkt_done_d = 1'b1;
                        pkt_err_d  = err_seen_q | err;
                        grant_d    = '0;
                        state_d    = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= RR_RESET;
            out_byte_q  <= 8'h00;
            out_full_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
            remaining_q <= 6'd0;
            parity_q    <= 8'h00;
            gap_cnt_q   <= '0;
            err_seen_q  <= 1'b0;
            hdr_err_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            src_abort_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_byte_q  <= out_byte_d;
            out_full_q  <= out_full_d;
            pkt_valid_q <= pkt_valid_d;
            remaining_q <= remaining_d;
            parity_q    <= parity_d;
            gap_cnt_q   <= gap_cnt_d;
            err_seen_q  <= err_seen_d;
            hdr_err_q   <= hdr_err_d;
            pkt_done_q  <= pkt_done_d;
            pkt_err_q   <= pkt_err_d;
            src_abort_q <= src_abort_d;
        end
    end

    assign data_in   = out_byte_q;
    assign pkt_valid = pkt_valid_q;
    assign grant     = grant_q;
    assign hdr_err   = hdr_err_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_err   = pkt_err_q;
    assign src_abort = src_abort_q;
    assign dbg_state = state_q;

endmodule
